// File: rtl/nes_pkg.sv
// Shared NES definitions: DMA FSM state encoding and fixed CPU-bus addresses.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-snoop and DMA bus-master signals of the sprite-DMA engine.
// master: the DMA engine itself; slave: the CPU/memory side it talks to.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic        rdy;
  logic        dma_grant;
  logic [15:0] dma_addr;
  logic        dma_wr;
  logic [7:0]  dma_dout;
  logic [7:0]  dma_din;
  logic        done;

  modport master (
    input  cpu_addr, cpu_wr, cpu_dout, dma_din,
    output rdy, dma_grant, dma_addr, dma_wr, dma_dout, done
  );

  modport slave (
    output cpu_addr, cpu_wr, cpu_dout, dma_din,
    input  rdy, dma_grant, dma_addr, dma_wr, dma_dout, done
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite-DMA engine: snoops CPU writes to the DMA page register, halts the
// CPU, copies one 256-byte page to the OAM data port with get/put alignment
// and then hands the bus back. All outputs are registered.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = nes_pkg::OAM_DMA_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_pkg::OAM_DATA_ADDR
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);
  import nes_pkg::*;

  dma_state_e  state_q;
  logic        parity_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic        rdy_q;
  logic        grant_q;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [7:0]  dout_q;
  logic        done_q;
  logic        trig_d;

  // The index wraps inside the page and never carries into page_q.
  assign idx_d  = idx_q + 8'd1;
  assign trig_d = bus.cpu_wr && (bus.cpu_addr == DMA_REG_ADDR);

  // Transfer FSM; outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      rdy_q    <= 1'b1;
      grant_q  <= 1'b0;
      addr_q   <= 16'h0000;
      wr_q     <= 1'b0;
      dout_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      // get/put phase of the CPU, free-running from reset
      parity_q <= ~parity_q;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig_d) begin
            page_q  <= bus.cpu_dout;
            rdy_q   <= 1'b0;
            state_q <= HALT;
          end
        end
        HALT: begin
          // an odd HALT cycle needs one extra cycle to reach a get phase
          if (parity_q) begin
            state_q <= ALIGN;
          end else begin
            state_q <= READ;
            grant_q <= 1'b1;
            addr_q  <= {page_q, idx_q};
          end
        end
        ALIGN: begin
          state_q <= READ;
          grant_q <= 1'b1;
          addr_q  <= {page_q, idx_q};
        end
        READ: begin
          // dout_q doubles as the data register holding the fetched byte
          dout_q  <= bus.dma_din;
          addr_q  <= OAM_DATA_ADDR;
          wr_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          idx_q <= idx_d;
          wr_q  <= 1'b0;
          if (idx_q == 8'hFF) begin
            state_q <= DONE;
            grant_q <= 1'b0;
            addr_q  <= 16'h0000;
            rdy_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
            addr_q  <= {page_q, idx_d};
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.dma_grant = grant_q;
  assign bus.dma_addr  = addr_q;
  assign bus.dma_wr    = wr_q;
  assign bus.dma_dout  = dout_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: each trigger queues the expected reads,
// writes and halt length; a negedge monitor pops and compares them.
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tpar;

  always #5 clk = ~clk;

  oam_dma_if bus();

  oam_dma dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory contents: page 0x02 holds i ^ 8'h5A; other pages differ.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h58;
  endfunction

  assign bus.dma_din = mem_rd(bus.dma_addr);

  // Independent model of the CPU get/put phase.
  always @(posedge clk or posedge rst) begin
    if (rst) tpar <= 1'b0;
    else     tpar <= ~tpar;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int          len_q[$];
  int          rdy_low   = 0;
  int          wr_seen   = 0;
  int          done_seen = 0;
  int          exp_done  = 0;
  logic        prev_wr   = 1'b0;

  // Monitor: compare bus activity against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      rdy_low = 0;
      wr_seen = 0;
      prev_wr = 1'b0;
    end else begin
      if (!bus.rdy) rdy_low++;
      if (bus.dma_grant && !bus.dma_wr) begin
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else begin
          check("rd_addr", bus.dma_addr, rd_q.pop_front());
          check("rd_rdy", bus.rdy, 0);
        end
      end
      if (bus.dma_wr) begin
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          check("wr_addr", bus.dma_addr, 16'h2004);
          check("wr_data", bus.dma_dout, wr_q.pop_front());
          check("wr_grant", bus.dma_grant, 1);
        end
        wr_seen++;
      end
      if (bus.done) begin
        done_seen++;
        check("done_after_wr", prev_wr, 1);
        check("done_rdy", bus.rdy, 1);
        check("done_grant", bus.dma_grant, 0);
        if (len_q.size() == 0) check("done_extra", 1, 0);
        else check("halt_len", rdy_low, len_q.pop_front());
        rdy_low = 0;
        wr_seen = 0;
      end
      prev_wr = bus.dma_wr;
    end
  end

  // align: 0/1 forces the parity seen in HALT, -1 triggers immediately.
  task automatic start_dma(input logic [7:0] pg, input int align);
    int hp;
    int n;
    if (align >= 0) begin
      n = 0;
      while ((tpar == align[0]) && n < 4) begin
        @(negedge clk);
        n++;
      end
    end
    hp = tpar ? 0 : 1;
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({pg, i[7:0]});
      wr_q.push_back(mem_rd({pg, i[7:0]}));
    end
    len_q.push_back(513 + hp);
    exp_done++;
    bus.cpu_addr = 16'h4014;
    bus.cpu_dout = pg;
    bus.cpu_wr   = 1'b1;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 16'h0000;
    check("halt_rdy", bus.rdy, 0);
    check("halt_grant", bus.dma_grant, 0);
    n = 0;
    while (!bus.dma_grant && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("first_read_lat", n, 1 + hp);
  endtask

  task automatic wait_done(input bit retrig);
    int n;
    n = 0;
    while (!bus.done && n < 1200) begin
      if (retrig && n == 40) begin
        bus.cpu_addr = 16'h4014; bus.cpu_dout = 8'h03; bus.cpu_wr = 1'b1;
      end else if (retrig && n == 91) begin
        bus.cpu_addr = 16'h4015; bus.cpu_dout = 8'h07; bus.cpu_wr = 1'b1;
      end else begin
        bus.cpu_wr = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.cpu_wr = 1'b0;
    check("done_timeout", (n < 1200), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cpu_addr = 16'h0000;
    bus.cpu_wr   = 1'b0;
    bus.cpu_dout = 8'h00;
    #12;
    check("rst_rdy",   bus.rdy, 1);
    check("rst_grant", bus.dma_grant, 0);
    check("rst_addr",  bus.dma_addr, 0);
    check("rst_wr",    bus.dma_wr, 0);
    check("rst_dout",  bus.dma_dout, 0);
    check("rst_done",  bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // even alignment, then odd alignment
    start_dma(8'h02, 0);
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    start_dma(8'h02, 1);
    wait_done(1'b0);
    repeat (2) @(negedge clk);

    // page wrap at the top of memory
    start_dma(8'hFF, -1);
    wait_done(1'b0);
    repeat (2) @(negedge clk);

    // re-trigger and foreign-address writes during a transfer
    start_dma(8'h02, -1);
    wait_done(1'b1);
    repeat (2) @(negedge clk);

    // foreign-address write while idle
    bus.cpu_addr = 16'h4015; bus.cpu_dout = 8'h02; bus.cpu_wr = 1'b1;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_4015_rdy", bus.rdy, 1);
      check("idle_4015_grant", bus.dma_grant, 0);
    end

    // reset in the middle of a transfer
    start_dma(8'h02, -1);
    n = 0;
    while (wr_seen < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach100", (wr_seen >= 100), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy",   bus.rdy, 1);
    check("mid_rst_grant", bus.dma_grant, 0);
    check("mid_rst_wr",    bus.dma_wr, 0);
    check("mid_rst_done",  bus.done, 0);
    rd_q.delete();
    wr_q.delete();
    len_q.delete();
    exp_done--;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_dma(8'h04, -1);
    wait_done(1'b0);

    // back-to-back: trigger in the idle cycle right after done
    @(negedge clk);
    start_dma(8'h05, -1);
    wait_done(1'b0);
    repeat (3) @(negedge clk);

    check("done_count", done_seen, exp_done);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("len_q_empty", len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA engine on the CPU bus, between `cpu_top` and `mem_top`. Snoops CPU writes to the DMA page register. On a hit it halts the CPU via `rdy`, takes bus ownership, and copies 256 bytes from page `{page,8'h00}` to the OAM data port with NES-accurate cycle counts. It then returns the bus and releases the CPU.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every byte.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_addr` in 16: CPU bus address.
- `cpu_wr` in 1: CPU write strobe, valid for one cycle.
- `cpu_dout` in 8: CPU write data.
- `rdy` out 1: CPU ready; 0 halts CPU.
- `dma_grant` out 1: 1 selects DMA as bus master in the memory mux.
- `dma_addr` out 16: DMA bus address.
- `dma_wr` out 1: DMA write strobe.
- `dma_dout` out 8: DMA write data.
- `dma_din` in 8: memory read data, combinational within the cycle the address is driven.
- `done` out 1: one-cycle pulse after the last write.

## Operation
- Reset values: `rdy`=1, `dma_grant`=0, `dma_addr`=0, `dma_wr`=0, `dma_dout`=0, `done`=0, state IDLE, `idx`=0, `parity`=0.
- `parity` toggles every clk from reset; it models the CPU get/put cycle.
- Trigger: in IDLE, `cpu_wr && cpu_addr==DMA_REG_ADDR`, sampled at a clk edge, latches `page<=cpu_dout` and moves to HALT.
- States and transitions:
  - IDLE → HALT on trigger.
  - HALT, 1 cycle: `rdy`=0, `dma_grant`=0. Goes to ALIGN if `parity`=1 in this cycle, else to READ.
  - ALIGN, 1 cycle: `rdy`=0, `dma_grant`=0. Goes to READ.
  - READ: `dma_grant`=1, `dma_addr`={page,idx}, `dma_wr`=0. Latches `dma_din` into the data register at the edge. Goes to WRITE.
  - WRITE: `dma_grant`=1, `dma_addr`=OAM_DATA_ADDR, `dma_wr`=1, `dma_dout`=latched byte. `idx<=idx+1` (8-bit). Goes to READ, or to DONE when `idx`==8'hFF.
  - DONE, 1 cycle: `done`=1, `rdy`=1, `dma_grant`=0. Goes to IDLE.
- `rdy`=0 from HALT through the final WRITE inclusive.
- Source address stays inside the page: `idx` wraps 8'hFF→8'h00 and never carries into `page`.
- Triggers outside IDLE are ignored; `page` is not re-latched.
- `cpu_wr` to any other address has no effect.
- `rst` asserted mid-transfer: immediate return to reset values. The partial transfer is abandoned; no `done` pulse.

## Timing
- Halt length, counting `rdy`=0 cycles:
  - 513 when the trigger edge leaves `parity`=0 in HALT.
  - 514 with ALIGN.
  - Breakdown: 1 HALT + 0/1 ALIGN + 512 transfer.
- First READ is 1 or 2 cycles after the trigger edge.
- `done` comes 1 cycle after the last WRITE.
- A new trigger is accepted the cycle after DONE.
- All outputs are registered or decoded from state only; no combinational path from `cpu_*` to outputs.
- Write data is delayed from its read by exactly 1 cycle.

## Structure
- Shared package `nes_pkg` holds:
  - `dma_state_e` enum {IDLE, HALT, ALIGN, READ, WRITE, DONE}.
  - Constants `OAM_DMA_ADDR`=16'h4014 and `OAM_DATA_ADDR`=16'h2004, used as parameter defaults.
- No sub-module: a single FSM with an 8-bit index, a page register and a data register.
- Bus muxing by `dma_grant` lives in the memory-side top, not in this block.

## Test plan
- Even alignment: write 8'h02 to 16'h4014 with HALT on `parity`=0; page 0x0200 holds i^8'h5A → 256 writes of i^8'h5A to 0x2004 in order, `rdy` low exactly 513 cycles, one `done` pulse.
- Odd alignment: same trigger placed one cycle later → ALIGN visited, `rdy` low 514 cycles, data identical.
- Wrap: page 8'hFF → reads cover 0xFF00–0xFFFF only; no access to 0x0000; `idx` returns to 0.
- Re-trigger: CPU write 8'h03 to 16'h4014 during READ/WRITE → ignored; transfer still sources page 0x02; a 16'h4015 write is also ignored.
- Reset mid-op: assert `rst` at byte 100 → `rdy`=1 and `dma_grant`=0 immediately, no `done`; a fresh trigger after release performs a full 256-byte copy.
- Back-to-back: trigger the cycle after `done` → second DMA starts normally with correct cycle count.
